// File: rtl/usb_pin_event_ctrl_if.sv
// ============================================================================
// Module   : usb_pin_event_ctrl_if
// Brief    : Avalon-MM slave bus bundle for the USB pin event controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface usb_pin_event_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write,
    output writedata,
    input  readdata
  );
endinterface

`default_nettype wire

// File: rtl/usb_pin_event_ctrl.sv
// ============================================================================
// Module   : usb_pin_event_ctrl
// Brief    : Synchronizes, glitch-filters and edge-captures the MAX3421E GPX/INT
//            pins, with maskable interrupt and a saturating GPX event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_pin_event_ctrl #(
  parameter int FILTER_RST = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  usb_pin_event_ctrl_if.slave avs,
  input  wire logic           usb_gpx,
  input  wire logic           usb_int,
  output logic                irq
);

  localparam logic [7:0]       C_FILTER_RST = 8'(FILTER_RST);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

  localparam logic [2:0] C_ADDR_DATA     = 3'd0;
  localparam logic [2:0] C_ADDR_IRQ_MASK = 3'd1;
  localparam logic [2:0] C_ADDR_EDGE_CAP = 3'd2;
  localparam logic [2:0] C_ADDR_EDGE_SEL = 3'd3;
  localparam logic [2:0] C_ADDR_FILTER   = 3'd4;
  localparam logic [2:0] C_ADDR_EVCNT    = 3'd5;

  // Bit 0 is GPX, bit 1 is INT throughout.
  logic [1:0]       pin_raw;
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       f_q, f_d;
  logic [1:0]       fd_q, fd_d;
  logic [1:0][7:0]  cnt_q, cnt_d;
  logic [1:0]       edge_cap_q, edge_cap_d;
  logic [1:0]       irq_mask_q, irq_mask_d;
  logic [3:0]       edge_sel_q, edge_sel_d;
  logic [7:0]       filter_len_q, filter_len_d;
  logic [CNT_W-1:0] event_count_q, event_count_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [1:0]       rise;
  logic [1:0]       fall;
  logic [1:0]       ev;
  logic             bus_wr;
  logic             bus_rd;
  logic             wr_filter;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign pin_raw      = {usb_int, usb_gpx};
  assign bus_wr       = avs.chipselect & avs.write;
  assign bus_rd       = avs.chipselect & ~avs.write;
  assign wr_filter    = bus_wr && (avs.address == C_ADDR_FILTER);
  assign unused_wdata = ^avs.writedata[31:8];

  assign sync1_d = pin_raw;
  assign sync2_d = sync1_q;
  assign fd_d    = f_q;

  // A mismatch must persist for FILTER_LEN+1 cycles before f follows s.
  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (wr_filter) begin
        cnt_d[i] = 8'd0;
      end else if (sync2_q[i] == f_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == filter_len_q) begin
        f_d[i]   = sync2_q[i];
        cnt_d[i] = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_pin
    assign rise[gi] = f_q[gi] & ~fd_q[gi];
    assign fall[gi] = ~f_q[gi] & fd_q[gi];
    assign ev[gi]   = (rise[gi] & edge_sel_q[2*gi]) | (fall[gi] & edge_sel_q[2*gi+1]);
  end

  always_comb begin
    irq_mask_d   = irq_mask_q;
    edge_sel_d   = edge_sel_q;
    filter_len_d = filter_len_q;
    edge_cap_d   = edge_cap_q;

    if (bus_wr && (avs.address == C_ADDR_IRQ_MASK)) irq_mask_d   = avs.writedata[1:0];
    if (bus_wr && (avs.address == C_ADDR_EDGE_SEL)) edge_sel_d   = avs.writedata[3:0];
    if (wr_filter)                                  filter_len_d = avs.writedata[7:0];
    if (bus_wr && (avs.address == C_ADDR_EDGE_CAP)) edge_cap_d   = edge_cap_q & ~avs.writedata[1:0];

    // New events are ORed in after the clear so a simultaneous set wins.
    edge_cap_d = edge_cap_d | ev;
  end

  always_comb begin
    event_count_d = event_count_q;
    if (bus_wr && (avs.address == C_ADDR_EVCNT)) begin
      event_count_d = ev[0] ? C_CNT_ONE : '0;
    end else if (ev[0] && (event_count_q != C_CNT_MAX)) begin
      event_count_d = event_count_q + C_CNT_ONE;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (avs.address)
      C_ADDR_DATA:     rd_mux = {30'd0, f_q};
      C_ADDR_IRQ_MASK: rd_mux = {30'd0, irq_mask_q};
      C_ADDR_EDGE_CAP: rd_mux = {30'd0, edge_cap_q};
      C_ADDR_EDGE_SEL: rd_mux = {28'd0, edge_sel_q};
      C_ADDR_FILTER:   rd_mux = {24'd0, filter_len_q};
      C_ADDR_EVCNT:    rd_mux = 32'(event_count_q);
      default:         rd_mux = 32'd0;
    endcase
    readdata_d = bus_rd ? rd_mux : 32'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= 2'b00;
      sync2_q       <= 2'b00;
      f_q           <= 2'b00;
      fd_q          <= 2'b00;
      cnt_q         <= '0;
      edge_cap_q    <= 2'b00;
      irq_mask_q    <= 2'b00;
      edge_sel_q    <= 4'd0;
      filter_len_q  <= C_FILTER_RST;
      event_count_q <= '0;
      readdata_q    <= 32'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      f_q           <= f_d;
      fd_q          <= fd_d;
      cnt_q         <= cnt_d;
      edge_cap_q    <= edge_cap_d;
      irq_mask_q    <= irq_mask_d;
      edge_sel_q    <= edge_sel_d;
      filter_len_q  <= filter_len_d;
      event_count_q <= event_count_d;
      readdata_q    <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

`default_nettype wire

// File: tb/tb_usb_pin_event_ctrl.sv
// ============================================================================
// Module   : tb_usb_pin_event_ctrl
// Brief    : Directed self-checking bench for usb_pin_event_ctrl (CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_pin_event_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic usb_gpx;
  logic usb_int;
  logic irq;

  usb_pin_event_ctrl_if bus ();

  usb_pin_event_ctrl #(
    .FILTER_RST (4),
    .CNT_W      (4)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .usb_gpx (usb_gpx),
    .usb_int (usb_int),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;
  logic [31:0] ex;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write      = 1'b0;
    bus.address    = addr;
    tick();
    data = bus.readdata;
    bus_idle();
  endtask

  task automatic add(input bit wr, input logic [2:0] addr, input logic [31:0] data,
                     input logic [31:0] exp, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    usb_gpx = 1'b0;
    usb_int = 1'b0;
    bus_idle();
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Register-level vectors: reset values, field widths, unused addresses.
    add(0, 3'd0, 0, 32'h0,  "rst_data");
    add(0, 3'd1, 0, 32'h0,  "rst_mask");
    add(0, 3'd2, 0, 32'h0,  "rst_cap");
    add(0, 3'd3, 0, 32'h0,  "rst_sel");
    add(0, 3'd4, 0, 32'h4,  "rst_filter");
    add(0, 3'd5, 0, 32'h0,  "rst_evcnt");
    add(0, 3'd6, 0, 32'h0,  "rd_addr6");
    add(0, 3'd7, 0, 32'h0,  "rd_addr7");
    add(1, 3'd1, 32'hFFFF_FFFF, 0, "");
    add(0, 3'd1, 0, 32'h3,  "mask_width");
    add(1, 3'd3, 32'hFFFF_FFFF, 0, "");
    add(0, 3'd3, 0, 32'hF,  "sel_width");
    add(1, 3'd4, 32'h0000_01FF, 0, "");
    add(0, 3'd4, 0, 32'hFF, "filter_width");
    add(1, 3'd6, 32'h0000_FFFF, 0, "");
    add(0, 3'd6, 0, 32'h0,  "wr_addr6");
    add(1, 3'd0, 32'h3, 0, "");
    add(0, 3'd0, 0, 32'h0,  "data_ro");
    add(1, 3'd1, 32'h0, 0, "");
    add(1, 3'd3, 32'h0, 0, "");
    add(1, 3'd4, 32'h4, 0, "");
    add(0, 3'd4, 0, 32'h4,  "filter_restore");

    foreach (vecs[k]) begin
      if (vecs[k].wr) begin
        bus_write(vecs[k].addr, vecs[k].data);
      end else begin
        bus_read(vecs[k].addr, rd);
        check(vecs[k].name, rd, vecs[k].exp);
      end
    end

    // Filter reject then accept, FILTER_LEN=4, GPX rising.
    bus_write(3'd3, 32'h1);
    bus_write(3'd1, 32'h1);
    bus.chipselect = 1'b1;
    bus.address    = 3'd0;
    usb_gpx = 1'b1;
    repeat (3) tick();
    usb_gpx = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("short_pulse_data", bus.readdata, 32'd0);
      check("short_pulse_irq", {31'd0, irq}, 32'd0);
    end
    usb_gpx = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) usb_gpx = 1'b0;
      ex = (e >= 8) ? 32'd1 : 32'd0;
      check("long_pulse_data", bus.readdata, ex);
      check("long_pulse_irq", {31'd0, irq}, ex);
    end
    bus_idle();
    repeat (12) tick();
    bus_read(3'd2, rd);
    check("long_pulse_cap", rd, 32'h1);
    bus_write(3'd2, 32'h1);
    check("w1c_irq_drop", {31'd0, irq}, 32'd0);
    bus_read(3'd2, rd);
    check("w1c_cap", rd, 32'h0);

    // Edge select: INT both edges, GPX falling only, FILTER_LEN=0.
    bus_write(3'd4, 32'h0);
    bus_write(3'd3, 32'hE);
    bus_write(3'd1, 32'h3);
    usb_int = 1'b1;
    repeat (6) tick();
    bus_read(3'd2, rd);
    check("int_rise_cap", rd, 32'h2);
    check("int_rise_irq", {31'd0, irq}, 32'd1);
    bus_write(3'd2, 32'h2);
    usb_int = 1'b0;
    repeat (6) tick();
    bus_read(3'd2, rd);
    check("int_fall_cap", rd, 32'h2);
    bus_write(3'd2, 32'h3);
    usb_gpx = 1'b1;
    repeat (6) tick();
    bus_read(3'd2, rd);
    check("gpx_rise_ignored", rd, 32'h0);
    check("gpx_rise_irq", {31'd0, irq}, 32'd0);
    usb_gpx = 1'b0;
    repeat (6) tick();
    bus_read(3'd2, rd);
    check("gpx_fall_cap", rd, 32'h1);
    check("gpx_fall_irq", {31'd0, irq}, 32'd1);

    // W1C on the same edge as a new GPX event: set wins.
    bus_write(3'd3, 32'hD);
    usb_gpx = 1'b1;
    repeat (3) tick();
    bus_write(3'd2, 32'h1);
    check("race_irq", {31'd0, irq}, 32'd1);
    bus_read(3'd2, rd);
    check("race_cap", rd, 32'h1);
    bus_write(3'd2, 32'h1);
    check("clear_irq", {31'd0, irq}, 32'd0);
    bus_read(3'd2, rd);
    check("clear_cap", rd, 32'h0);

    // Event counter saturation at 4 bits, and clear racing an event.
    bus_write(3'd3, 32'h3);
    bus_write(3'd5, 32'h0);
    bus_read(3'd5, rd);
    check("evcnt_clear", rd, 32'h0);
    for (int n = 0; n < 20; n++) begin
      usb_gpx = ~usb_gpx;
      repeat (4) tick();
    end
    repeat (4) tick();
    bus_read(3'd5, rd);
    check("evcnt_saturate", rd, 32'hF);
    usb_gpx = ~usb_gpx;
    repeat (3) tick();
    bus_write(3'd5, 32'h1234);
    repeat (3) tick();
    bus_read(3'd5, rd);
    check("evcnt_clear_race", rd, 32'h1);

    // FILTER_LEN rewritten while a mismatch count is at 6.
    bus_write(3'd2, 32'h3);
    bus_write(3'd1, 32'h1);
    bus_write(3'd4, 32'd10);
    repeat (2) tick();
    usb_gpx = ~usb_gpx;
    repeat (8) tick();
    bus_write(3'd4, 32'd2);
    for (int e = 10; e <= 13; e++) begin
      tick();
      ex = (e == 13) ? 32'd1 : 32'd0;
      check("filter_rewrite_irq", {31'd0, irq}, ex);
    end

    // Asynchronous reset mid-pulse with irq asserted.
    bus.chipselect = 1'b1;
    bus.address    = 3'd2;
    tick();
    check("pre_reset_readdata", bus.readdata, 32'h1);
    usb_int = 1'b1;
    usb_gpx = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    check("async_rst_readdata", bus.readdata, 32'd0);
    bus_idle();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    bus_read(3'd4, rd);
    check("post_rst_filter", rd, 32'h4);
    bus_read(3'd2, rd);
    check("post_rst_cap", rd, 32'h0);
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    bus_read(3'd0, rd);
    check("post_rst_data", rd, 32'h3);
    bus_read(3'd5, rd);
    check("post_rst_evcnt", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
